// File: rtl/motoro3_pkg.sv
// Shared hall/drive definitions: sector code map, FSM state encoding and period width.
package motoro3_pkg;

  localparam int PERIOD_W = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] sector;
  } sector_t;

  // Hall code is ordered {C,B,A}; 000 and 111 can never occur on a healthy motor.
  function automatic sector_t code_to_sector(input logic [2:0] cba);
    sector_t r;
    r.legal  = 1'b1;
    r.sector = 3'd0;
    case (cba)
      3'b001:  r.sector = 3'd0;
      3'b011:  r.sector = 3'd1;
      3'b010:  r.sector = 3'd2;
      3'b110:  r.sector = 3'd3;
      3'b100:  r.sector = 3'd4;
      3'b101:  r.sector = 3'd5;
      default: r.legal  = 1'b0;
    endcase
    return r;
  endfunction

  // Sector distance (to - from) mod 6.
  function automatic logic [2:0] sector_delta(input logic [2:0] from_s, input logic [2:0] to_s);
    logic [3:0] d;
    d = {1'b0, to_s} + 4'd6 - {1'b0, from_s};
    if (d >= 4'd6) d = d - 4'd6;
    return d[2:0];
  endfunction

endpackage

// File: rtl/motoro3_hall_filter.sv
// Two-flop synchroniser per hall line followed by an N-sample agreement filter.
module motoro3_hall_filter #(
  parameter int W        = 3,
  parameter int FILT_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] code_o,
  output logic         new_o
);

  localparam logic [7:0] CNT_MAX = 8'(FILT_LEN);
  localparam logic [7:0] CNT_ACC = 8'(FILT_LEN - 1);

  logic [W-1:0] sync1_q, sync2_q, cand_q, filt_q;
  logic [7:0]   cnt_q;
  logic         new_q;

  // new_q fires in the same cycle filt_q takes a different code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= 8'd0;
      new_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      new_q   <= 1'b0;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= 8'd1;
      end else if (cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
        if (cnt_q == CNT_ACC && cand_q != filt_q) begin
          filt_q <= cand_q;
          new_q  <= 1'b1;
        end
      end
    end
  end

  assign code_o = filt_q;
  assign new_o  = new_q;

endmodule

// File: rtl/motoro3_hall_decoder.sv
// Hall sensor decoder: sector/direction tracking, edge-to-edge period, fault and stall flags.
module motoro3_hall_decoder
  import motoro3_pkg::*;
#(
  parameter int FILT_LEN  = 16,
  parameter int STALL_CYC = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hallA,
  input  logic                hallB,
  input  logic                hallC,
  input  logic                hdFaultClr,
  output logic [2:0]          hdSector,
  output logic                hdDir,
  output logic                hdStep,
  output logic [PERIOD_W-1:0] hdPeriod,
  output logic                hdValid,
  output logic                hdFault,
  output logic                hdStall,
  output state_e              hdState
);

  localparam logic [PERIOD_W-1:0] STALL_VAL = PERIOD_W'(STALL_CYC);
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

  logic [2:0]          code;
  logic                code_new;
  sector_t             dec;
  logic [2:0]          delta;

  state_e              state_q, state_d;
  logic [2:0]          sector_q, sector_d;
  logic                dir_q, dir_d, step_q, step_d, valid_q, valid_d;
  logic                fault_q, fault_d, stall_q, stall_d, fault_set;
  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;

  motoro3_hall_filter #(.W(3), .FILT_LEN(FILT_LEN)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .raw_i  ({hallC, hallB, hallA}),
    .code_o (code),
    .new_o  (code_new)
  );

  assign dec   = code_to_sector(code);
  assign delta = sector_delta(sector_q, dec.sector);

  always_comb begin
    state_d   = state_q;
    sector_d  = sector_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    period_d  = period_q;
    valid_d   = valid_q;
    stall_d   = stall_q;
    fault_set = 1'b0;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (code_new && dec.legal) begin
          state_d  = ST_SYNC;
          sector_d = dec.sector;
          cnt_d    = CNT_ONE;
        end else if (code_new) begin
          fault_set = 1'b1;
        end
      end
      ST_SYNC, ST_RUN: begin
        if (code_new) begin
          if (dec.legal && (delta == 3'd1 || delta == 3'd5)) begin
            dir_d    = (delta == 3'd5);
            step_d   = 1'b1;
            sector_d = dec.sector;
            cnt_d    = CNT_ONE;
            stall_d  = 1'b0;
            state_d  = ST_RUN;
            // The first edge after SYNC has no previous edge to measure from.
            if (state_q == ST_RUN) begin
              period_d = cnt_q;
              valid_d  = 1'b1;
            end
          end else begin
            fault_set = 1'b1;
            valid_d   = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (cnt_q == STALL_VAL) begin
          stall_d  = 1'b1;
          valid_d  = 1'b0;
          period_d = '1;
          state_d  = ST_SYNC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fault arriving with the clear pulse wins.
    fault_d = fault_set | (fault_q & ~hdFaultClr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sector_q <= 3'd0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      stall_q  <= 1'b0;
      cnt_q    <= CNT_ONE;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      stall_q  <= stall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hdSector = sector_q;
  assign hdDir    = dir_q;
  assign hdStep   = step_q;
  assign hdPeriod = period_q;
  assign hdValid  = valid_q;
  assign hdFault  = fault_q;
  assign hdStall  = stall_q;
  assign hdState  = state_q;

endmodule

// File: tb/tb_motoro3_hall_decoder.sv
// Directed bench for motoro3_hall_decoder with a shortened stall timeout.
module tb_motoro3_hall_decoder;
  import motoro3_pkg::*;

  localparam int FILT_LEN  = 16;
  localparam int STALL_CYC = 3000;
  localparam int LAT       = 3 + FILT_LEN;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [2:0]          hall = 3'b000;
  logic                hdFaultClr = 1'b0;
  logic [2:0]          hdSector;
  logic                hdDir, hdStep, hdValid, hdFault, hdStall;
  logic [PERIOD_W-1:0] hdPeriod;
  state_e              hdState;

  int vec  = 0;
  int miss = 0;

  motoro3_hall_decoder #(.FILT_LEN(FILT_LEN), .STALL_CYC(STALL_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .hallA      (hall[0]),
    .hallB      (hall[1]),
    .hallC      (hall[2]),
    .hdFaultClr (hdFaultClr),
    .hdSector   (hdSector),
    .hdDir      (hdDir),
    .hdStep     (hdStep),
    .hdPeriod   (hdPeriod),
    .hdValid    (hdValid),
    .hdFault    (hdFault),
    .hdStall    (hdStall),
    .hdState    (hdState)
  );

  always #50 clk = ~clk;

  // Called right after a posedge; applies a code, checks the exact-latency edge, then
  // waits so the next application lands exactly dwell cycles after this one.
  task automatic apply(input logic [2:0] cba, input int dwell, input logic exp_step,
                       input logic [2:0] exp_sec, input logic exp_dir, input logic exp_valid,
                       input logic [PERIOD_W-1:0] exp_per, input logic chk_per,
                       input state_e exp_st, input string name);
    #1 hall = cba;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdStep !== 1'b0) begin
      miss++; $display("FAIL %s early_step: got %b want 0", name, hdStep);
    end
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdStep !== exp_step) begin
      miss++; $display("FAIL %s step: got %b want %b", name, hdStep, exp_step);
    end
    vec++;
    if (hdSector !== exp_sec) begin
      miss++; $display("FAIL %s sector: got %0d want %0d", name, hdSector, exp_sec);
    end
    vec++;
    if (hdDir !== exp_dir) begin
      miss++; $display("FAIL %s dir: got %b want %b", name, hdDir, exp_dir);
    end
    vec++;
    if (hdValid !== exp_valid) begin
      miss++; $display("FAIL %s valid: got %b want %b", name, hdValid, exp_valid);
    end
    vec++;
    if (hdState !== exp_st) begin
      miss++; $display("FAIL %s state: got %0d want %0d", name, hdState, exp_st);
    end
    if (chk_per) begin
      vec++;
      if (hdPeriod !== exp_per) begin
        miss++; $display("FAIL %s period: got %0d want %0d", name, hdPeriod, exp_per);
      end
    end
    repeat (dwell - LAT) @(posedge clk);
  endtask

  task automatic clear_fault(input string name);
    #1 hdFaultClr = 1'b1;
    @(posedge clk);
    #1 hdFaultClr = 1'b0;
    @(negedge clk);
    vec++;
    if (hdFault !== 1'b0) begin
      miss++; $display("FAIL %s fault_clr: got %b want 0", name, hdFault);
    end
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    vec++;
    if ({hdSector, hdDir, hdStep, hdPeriod, hdValid, hdFault, hdStall} !== '0 ||
        hdState !== ST_IDLE) begin
      miss++;
      $display("FAIL %s outputs: got sec=%0d dir=%b step=%b per=%0d val=%b flt=%b stl=%b st=%0d want all 0/IDLE",
               name, hdSector, hdDir, hdStep, hdPeriod, hdValid, hdFault, hdStall, hdState);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_latency_glitch;
    int bad;
    apply(3'b001, 60, 1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, ST_SYNC, "first_sync");
    #1 hall = 3'b011;
    repeat (10) @(posedge clk);
    #1 hall = 3'b001;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (hdStep !== 1'b0 || hdSector !== 3'd0) bad++;
    end
    vec++;
    if (bad != 0) begin
      miss++; $display("FAIL glitch: got %0d disturbed cycles want 0", bad);
    end
    @(posedge clk);
    apply(3'b011, 200, 1'b1, 3'd1, 1'b0, 1'b0, '0, 1'b0, ST_RUN, "first_edge");
  endtask

  task automatic test_forward;
    apply(3'b010, 200, 1'b1, 3'd2, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd2");
    apply(3'b110, 200, 1'b1, 3'd3, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd3");
    apply(3'b100, 200, 1'b1, 3'd4, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd4");
    apply(3'b101, 200, 1'b1, 3'd5, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd5");
    apply(3'b001, 200, 1'b1, 3'd0, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd_wrap");
  endtask

  task automatic test_reversal;
    apply(3'b011, 200, 1'b1, 3'd1, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "rv_f1");
    apply(3'b010, 180, 1'b1, 3'd2, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "rv_f2");
    apply(3'b110, 150, 1'b1, 3'd3, 1'b0, 1'b1, 25'd180, 1'b1, ST_RUN, "rv_f3");
    apply(3'b010, 200, 1'b1, 3'd2, 1'b1, 1'b1, 25'd150, 1'b1, ST_RUN, "reverse");
    apply(3'b011, 120, 1'b1, 3'd1, 1'b1, 1'b1, 25'd200, 1'b1, ST_RUN, "rv_1");
    apply(3'b001, 200, 1'b1, 3'd0, 1'b1, 1'b1, 25'd120, 1'b1, ST_RUN, "rv_0");
    apply(3'b101, 200, 1'b1, 3'd5, 1'b1, 1'b1, 25'd200, 1'b1, ST_RUN, "rv_wrap");
    apply(3'b001, 200, 1'b1, 3'd0, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "fwd_again");
  endtask

  task automatic test_stall;
    apply(3'b011, LAT, 1'b1, 3'd1, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "pre_stall");
    repeat (STALL_CYC - 1) @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdStall !== 1'b0 || hdValid !== 1'b1) begin
      miss++; $display("FAIL stall_early: got stall=%b valid=%b want 0/1", hdStall, hdValid);
    end
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdStall !== 1'b1 || hdValid !== 1'b0 || hdState !== ST_SYNC) begin
      miss++; $display("FAIL stall_flag: got stall=%b valid=%b st=%0d want 1/0/%0d",
                       hdStall, hdValid, hdState, ST_SYNC);
    end
    vec++;
    if (hdPeriod !== 25'h1FFFFFF) begin
      miss++; $display("FAIL stall_period: got %h want 1ffffff", hdPeriod);
    end
    @(posedge clk);
    apply(3'b010, 200, 1'b1, 3'd2, 1'b0, 1'b0, 25'h1FFFFFF, 1'b1, ST_RUN, "stall_exit");
    vec++;
    if (hdStall !== 1'b0) begin
      miss++; $display("FAIL stall_clear: got %b want 0", hdStall);
    end
    apply(3'b110, 200, 1'b1, 3'd3, 1'b0, 1'b1, 25'd200, 1'b1, ST_RUN, "stall_second");
  endtask

  task automatic test_fault;
    apply(3'b111, 100, 1'b0, 3'd3, 1'b0, 1'b0, '0, 1'b0, ST_IDLE, "illegal");
    vec++;
    if (hdFault !== 1'b1) begin
      miss++; $display("FAIL illegal_fault: got %b want 1", hdFault);
    end
    clear_fault("illegal");
    apply(3'b001, 100, 1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, ST_SYNC, "resync");
    apply(3'b110, 100, 1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, ST_IDLE, "jump3");
    vec++;
    if (hdFault !== 1'b1) begin
      miss++; $display("FAIL jump_fault: got %b want 1", hdFault);
    end
    clear_fault("jump");
    apply(3'b011, 100, 1'b0, 3'd1, 1'b0, 1'b0, '0, 1'b0, ST_SYNC, "resync2");
    // Jump 1 -> 5 (two sectors back) with the clear pulse on the fault cycle.
    #1 hall = 3'b101;
    repeat (LAT - 1) @(posedge clk);
    #1 hdFaultClr = 1'b1;
    @(posedge clk);
    #1 hdFaultClr = 1'b0;
    @(negedge clk);
    vec++;
    if (hdFault !== 1'b1 || hdState !== ST_IDLE || hdStep !== 1'b0) begin
      miss++; $display("FAIL fault_vs_clr: got flt=%b st=%0d step=%b want 1/%0d/0",
                       hdFault, hdState, hdStep, ST_IDLE);
    end
    @(posedge clk);
    apply(3'b001, 60, 1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, ST_SYNC, "resync3");
    clear_fault("final");
  endtask

  task automatic test_reset_midrun;
    apply(3'b011, 100, 1'b1, 3'd1, 1'b0, 1'b0, '0, 1'b0, ST_RUN, "mr_first");
    apply(3'b010, 100, 1'b1, 3'd2, 1'b0, 1'b1, 25'd100, 1'b1, ST_RUN, "mr_second");
    #1 hall = 3'b110;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #10;
    check_reset_outputs("midrun_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdState !== ST_IDLE) begin
      miss++; $display("FAIL post_reset_idle: got %0d want %0d", hdState, ST_IDLE);
    end
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (hdState !== ST_SYNC || hdSector !== 3'd3 || hdStep !== 1'b0 || hdValid !== 1'b0) begin
      miss++; $display("FAIL post_reset_sync: got st=%0d sec=%0d step=%b val=%b want %0d/3/0/0",
                       hdState, hdSector, hdStep, hdValid, ST_SYNC);
    end
    @(posedge clk);
    apply(3'b100, 100, 1'b1, 3'd4, 1'b0, 1'b0, '0, 1'b0, ST_RUN, "post_reset_edge");
  endtask

  initial begin
    test_reset;
    test_latency_glitch;
    test_forward;
    test_reversal;
    test_stall;
    test_fault;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/motoro3_hall_decoder.md
MOTORO3_HALL_DECODER -- requirements
Module: motoro3_hall_decoder

Interface
REQ-001 Parameter FILT_LEN, default 16: consecutive identical synchronised samples required to accept a hall code (range 2..255).
REQ-002 Parameter STALL_CYC, default 2000000: clock cycles without an accepted edge before stall is declared (less than 2^25).
REQ-003 clk  input  1  system clock, 10 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hallA / hallB / hallC  input  1 each  raw asynchronous hall sensor levels from motor phases a/b/c.
REQ-006 hdFaultClr  input  1  single-cycle pulse that clears sticky hdFault.
REQ-007 hdSector  output  3  current electrical sector, 0..5.
REQ-008 hdDir  output  1  rotation direction: 0 = forward, 1 = reverse.
REQ-009 hdStep  output  1  one-cycle pulse per accepted adjacent-sector edge.
REQ-010 hdPeriod  output  25  clk cycles between the last two accepted edges.
REQ-011 hdValid  output  1  hdPeriod and hdDir are meaningful.
REQ-012 hdFault  output  1  sticky: illegal code or sector skip seen.
REQ-013 hdStall  output  1  no accepted edge for STALL_CYC cycles.

Function
REQ-014 Each hall input SHALL pass a 2-flop synchroniser; the 3-bit synchronised code SHALL be accepted as the filtered code only after FILT_LEN consecutive equal samples.
REQ-015 Code map (CBA): 001->0, 011->1, 010->2, 110->3, 100->4, 101->5; 000 and 111 are illegal.
REQ-016 Latency: a clean raw change SHALL appear on hdSector/hdStep exactly 3+FILT_LEN cycles later (19 at default).
REQ-017 FSM states: IDLE (no legal sector held), SYNC (one legal sector held, no edge yet), RUN (at least one accepted edge).
REQ-018 IDLE -> SYNC on first legal filtered code; hdSector loads, no hdStep, hdValid=0.
REQ-019 In SYNC/RUN, a filtered code change to sector (s+1) mod 6 SHALL set hdDir=0, and to (s+5) mod 6 SHALL set hdDir=1; both pulse hdStep, update hdSector, enter RUN.
REQ-020 Period counter: cleared to 1 on each accepted edge, +1 per cycle otherwise, saturating at 2^25-1; on an accepted edge in RUN, hdPeriod SHALL load the counter value (edge-to-edge cycle count) and hdValid SHALL be 1.
REQ-021 The first edge after SYNC SHALL pulse hdStep and set hdDir but SHALL NOT load hdPeriod; hdValid rises on the second edge.
REQ-022 Illegal filtered code or a jump of 2 or 3 sectors SHALL set hdFault, clear hdValid, drop to IDLE; no hdStep.
REQ-023 hdFault SHALL stay 1 until hdFaultClr; a fault and hdFaultClr in the same cycle SHALL leave hdFault=1.
REQ-024 When the counter reaches STALL_CYC in SYNC/RUN: hdStall=1, hdValid=0, hdPeriod=all-ones, state -> SYNC; hdStall clears on the next accepted edge.
REQ-025 A direction reversal SHALL be a normal accepted edge; hdPeriod measures the reversal interval.

Reset
REQ-026 On rst: synchronisers and filter = 000 with filter count 0, state IDLE, counter 1, hdSector=0, hdDir=0, hdStep=0, hdPeriod=0, hdValid=0, hdFault=0, hdStall=0.
REQ-027 Reset asserted mid-operation SHALL return to IDLE immediately; after release, the first legal code is treated as a fresh SYNC.

Structure
REQ-028 Shared package motoro3_pkg SHALL hold the sector code map, FSM state encoding, and 25-bit period width constant, reused by the drive-side state machine.
REQ-029 The synchroniser plus FILT_LEN glitch filter SHALL be sub-module motoro3_hall_filter (3-bit, parameterised); decode, FSM and period counter stay in the top.

Verification
REQ-030 Forward sequence 001,011,010,110,100,101, each held 166667 cycles -> hdDir=0, hdStep per edge, hdPeriod=166667 from second edge, hdValid=1.
REQ-031 Forward to sector 3, then code 010 -> hdDir=1, hdSector=2, hdStep, hdPeriod = actual dwell.
REQ-032 10-cycle glitch 011 inside a steady 001 (FILT_LEN=16) -> no hdStep, hdSector stays 0; code held 16 cycles -> accepted 19 cycles after raw change.
REQ-033 Code 111, or jump 001->110 -> hdFault=1, hdValid=0, IDLE; hdFaultClr pulse clears it; the next legal code re-enters SYNC.
REQ-034 Hold 010 for 2000000 cycles in RUN -> hdStall=1, hdPeriod=0x1FFFFFF; next legal edge clears hdStall, hdValid stays 0 until a second edge.
REQ-035 Assert rst mid-run -> all outputs at reset values within one cycle, and resume via SYNC after release.
